// File: rtl/rt_bcd_timer_pkg.sv
// Shared constants and types for the rt2 reaction-timer measurement stage.
// The game FSM and the display driver see the same defaults and BCD full scale.
package rt_bcd_timer_pkg;

    localparam int unsigned CLK_HZ_DEF    = 100_000_000;
    localparam int unsigned TICK_HZ_DEF   = 1000;
    localparam int unsigned TURBO_DIV_DEF = 100;
    localparam int unsigned NORMAL_DIV    = CLK_HZ_DEF / TICK_HZ_DEF;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [15:0] bcd_word_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;
    localparam bcd_word_t  BCD_MAX   = 16'h9999;

endpackage

// File: rtl/rt_bcd_timer_if.sv
// Control/result bundle between the game FSM (master) and the BCD timer (slave).
interface rt_bcd_timer_if;
    import rt_bcd_timer_pkg::*;

    logic      turbosim;
    logic      clear;
    logic      run;
    bcd_word_t bcd;
    logic      saturated;
    logic      tick_ms;

    modport master (
        output turbosim, clear, run,
        input  bcd, saturated, tick_ms
    );

    modport slave (
        input  turbosim, clear, run,
        output bcd, saturated, tick_ms
    );

endinterface

// File: rtl/rt_bcd_timer_digit.sv
// One decade (0-9) of the BCD counter; carry_o fires on the 9->0 step.
module rt_bcd_timer_digit
    import rt_bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       inc_i,
    output bcd_digit_t q_o,
    output logic       carry_o
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        q_d = q_q;
        if (clear_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = (q_q == DIGIT_MAX) ? '0 : q_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignment and reset asynchronously on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = inc_i & (q_q == DIGIT_MAX);

endmodule

// File: rtl/rt_bcd_timer.sv
// Millisecond prescaler plus a saturating 4-digit BCD elapsed-time counter.
// tick_ms is exported so the game FSM can time its own delays.
module rt_bcd_timer
    import rt_bcd_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned TICK_HZ   = TICK_HZ_DEF,
    parameter int unsigned TURBO_DIV = TURBO_DIV_DEF,
    parameter int unsigned PRE_W     = 17
) (
    input  logic          clk,
    input  logic          reset,
    rt_bcd_timer_if.slave bus
);

    localparam int unsigned NORM_DIV = CLK_HZ / TICK_HZ;
    localparam logic [PRE_W-1:0] NORM_LAST  = PRE_W'(NORM_DIV - 1);
    localparam logic [PRE_W-1:0] TURBO_LAST = PRE_W'(TURBO_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] div_last;
    logic             tick_q, tick_d;
    logic             sat_q, sat_d;
    logic             tick, step, all_nines, inc;
    bcd_word_t        digits;
    logic [4:0]       chain;
    logic             carry_unused;

    always_comb begin
        div_last  = bus.turbosim ? TURBO_LAST : NORM_LAST;
        // >= rather than == so a mid-count switch to the shorter divide wraps at once.
        tick      = (pre_q >= div_last);
        step      = bus.run & tick;
        all_nines = (digits == BCD_MAX);
        inc       = step & ~all_nines & ~bus.clear;

        pre_d  = tick ? '0 : pre_q + PRE_W'(1);
        tick_d = tick;
        sat_d  = sat_q | (step & all_nines);
        if (bus.clear) begin
            pre_d  = '0;
            tick_d = 1'b0;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            sat_q  <= sat_d;
        end
    end

    assign chain[0] = inc;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        rt_bcd_timer_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .clear_i (bus.clear),
            .inc_i   (chain[i]),
            .q_o     (digits[4*i +: 4]),
            .carry_o (chain[i+1])
        );
    end

    // Increments are gated at 9999, so the thousands carry never fires.
    assign carry_unused = chain[4];

    assign bus.bcd       = digits;
    assign bus.saturated = sat_q;
    assign bus.tick_ms   = tick_q;

endmodule

// File: tb/tb_rt_bcd_timer.sv
// Self-checking bench for rt_bcd_timer: directed scenarios plus random run/clear/turbosim
// traffic, compared every cycle against an integer-millisecond reference model.
module tb_rt_bcd_timer;

    localparam int T_DIV  = 3;
    localparam int N_DIV  = 16;
    localparam int TB_CLK = N_DIV * 1000;

    logic clk;
    logic reset;

    rt_bcd_timer_if bus_if ();

    rt_bcd_timer #(
        .CLK_HZ    (TB_CLK),
        .TICK_HZ   (1000),
        .TURBO_DIV (T_DIV),
        .PRE_W     (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: elapsed milliseconds as a plain integer, plus cycles since last tick.
    int m_since;
    int m_ms;
    bit m_sat;
    bit m_tick;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit nibbles_ok(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_since = 0;
        m_ms    = 0;
        m_sat   = 1'b0;
        m_tick  = 1'b0;
    endtask

    task automatic model_step();
        int div;
        bit t;
        if (bus_if.clear) begin
            model_reset();
        end else begin
            div     = bus_if.turbosim ? T_DIV : N_DIV;
            t       = (m_since + 1 >= div);
            m_since = t ? 0 : m_since + 1;
            m_tick  = t;
            if (bus_if.run && t) begin
                if (m_ms < 9999) m_ms = m_ms + 1;
                else             m_sat = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("bcd", bus_if.bcd, to_bcd(m_ms));
        check("saturated", bus_if.saturated, m_sat);
        check("tick_ms", bus_if.tick_ms, m_tick);
        check("nibble_legal", nibbles_ok(bus_if.bcd), 1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_clear();
        bus_if.clear = 1'b1;
        cycle();
        bus_if.clear = 1'b0;
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("async_bcd", bus_if.bcd, 16'h0000);
        check("async_sat", bus_if.saturated, 0);
        check("async_tick", bus_if.tick_ms, 0);
        #1 reset = 1'b1;
    endtask

    initial begin
        int ticks;
        reset           = 1'b0;
        bus_if.turbosim = 1'b1;
        bus_if.clear    = 1'b0;
        bus_if.run      = 1'b0;
        model_reset();

        // 1: reset values before any clock edge, then free-running tick with run low
        #2;
        check("rst_bcd", bus_if.bcd, 16'h0000);
        check("rst_sat", bus_if.saturated, 0);
        check("rst_tick", bus_if.tick_ms, 0);
        @(negedge clk);
        reset = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10 * T_DIV; i++) begin
            cycle();
            if (bus_if.tick_ms === 1'b1) ticks++;
        end
        check("t1_tick_count", ticks, 10);
        check("t1_bcd_idle", bus_if.bcd, 16'h0000);

        // 2: exact 1000 ms measurement, then hold with run low
        pulse_clear();
        bus_if.run = 1'b1;
        cycles(1000 * T_DIV);
        check("t2_1000ms", bus_if.bcd, 16'h1000);
        bus_if.run = 1'b0;
        cycles(1000);
        check("t2_hold", bus_if.bcd, 16'h1000);

        // 3: carry chain boundaries
        pulse_clear();
        bus_if.run = 1'b1;
        cycles(99 * T_DIV);
        check("t3_0099", bus_if.bcd, 16'h0099);
        cycles(T_DIV);
        check("t3_0100", bus_if.bcd, 16'h0100);
        cycles(899 * T_DIV);
        check("t3_0999", bus_if.bcd, 16'h0999);
        cycles(T_DIV);
        check("t3_1000", bus_if.bcd, 16'h1000);

        // 4: saturation at 9999
        pulse_clear();
        cycles(9999 * T_DIV);
        check("t4_9999", bus_if.bcd, 16'h9999);
        check("t4_not_sat", bus_if.saturated, 0);
        cycles(T_DIV);
        check("t4_sat_bcd", bus_if.bcd, 16'h9999);
        check("t4_sat", bus_if.saturated, 1);
        cycles(50 * T_DIV);
        check("t4_sticky_bcd", bus_if.bcd, 16'h9999);
        check("t4_sticky_sat", bus_if.saturated, 1);
        pulse_clear();
        check("t4_clr_bcd", bus_if.bcd, 16'h0000);
        check("t4_clr_sat", bus_if.saturated, 0);

        // 5: clear on the same edge as a tick wins, then exact restart
        cycles(T_DIV - 1);
        check("t5_pre_bcd", bus_if.bcd, 16'h0000);
        pulse_clear();
        check("t5_clr_bcd", bus_if.bcd, 16'h0000);
        check("t5_clr_tick", bus_if.tick_ms, 0);
        cycles(T_DIV - 1);
        check("t5_wait", bus_if.bcd, 16'h0000);
        cycle();
        check("t5_first", bus_if.bcd, 16'h0001);
        check("t5_first_tick", bus_if.tick_ms, 1);

        // 6: normal divide, mid-count switch to turbo, async reset mid-run
        bus_if.turbosim = 1'b0;
        pulse_clear();
        cycles(N_DIV - 1);
        check("t6_not_yet", bus_if.bcd, 16'h0000);
        cycle();
        check("t6_norm_1", bus_if.bcd, 16'h0001);
        cycles(N_DIV / 2);
        bus_if.turbosim = 1'b1;
        cycle();
        check("t6_wrap_bcd", bus_if.bcd, 16'h0002);
        check("t6_wrap_tick", bus_if.tick_ms, 1);
        cycles(T_DIV - 1);
        check("t6_turbo_wait", bus_if.bcd, 16'h0002);
        cycle();
        check("t6_turbo_3", bus_if.bcd, 16'h0003);
        cycle();
        async_reset();
        cycles(T_DIV);
        check("t6_resume", bus_if.bcd, 16'h0001);

        // Random traffic checked each cycle against the model
        for (int i = 0; i < 4000; i++) begin
            bus_if.run      = ($urandom % 8) != 0;
            bus_if.clear    = ($urandom % 64) == 0;
            bus_if.turbosim = ($urandom % 16) != 0;
            cycle();
        end
        bus_if.clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rt_bcd_timer.md
Name: rt_bcd_timer

Overview:
Reaction-time measurement stage of the rt2 reaction-timer game.
- Generates the millisecond tick from the 100 MHz clock.
- Accumulates elapsed milliseconds as a 4-digit BCD value, saturating at 9999.
- Sits between the game FSM, which drives clear/run, and the 7-segment display driver, which consumes bcd.
- tick_ms is also exported so the FSM can time its own delays (S_READY/S_STEADY).

Parameters:
CLK_HZ, 100_000_000, input clock frequency.
TICK_HZ, 1000, tick rate in normal mode (1 ms).
TURBO_DIV, 100, clocks per tick when turbosim=1 (1 game-ms = 1 us sim time).
PRE_W, 17, prescaler width; must hold max(CLK_HZ/TICK_HZ, TURBO_DIV)-1.

Ports:
clk  input  1  100 MHz system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
turbosim  input  1  1: divide by TURBO_DIV; 0: divide by CLK_HZ/TICK_HZ.
clear  input  1  synchronous clear of count, saturated and prescaler.
run  input  1  count enable; counting happens only while high.
bcd  output  16  {thousands,hundreds,tens,units}, one BCD digit per nibble.
saturated  output  1  high once the count has reached 9999 and another tick has arrived.
tick_ms  output  1  registered one-cycle pulse per tick; free-running except when clear is asserted.

Behaviour:
Reset
- reset low forces, immediately and without a clock edge: prescaler=0, bcd=16'h0000, saturated=0, tick_ms=0.
- Deasserting reset mid-run resumes from zero.

Prescaler
- DIV = turbosim ? TURBO_DIV : CLK_HZ/TICK_HZ.
- Internal tick = (pre >= DIV-1). On tick, pre<=0; otherwise pre<=pre+1.
- The >= compare makes a turbosim change mid-count wrap on the next edge, never run away.
- clear=1: pre<=0 and tick_ms<=0, regardless of tick.
- Consequence: the first increment after clear comes exactly DIV cycles after the clear edge, so measured time is exact, not ±1 lsb.

tick_ms
- Registered copy of the internal tick (when clear=0).
- High during the cycle in which the new bcd value is visible.

Counter (priority: clear > increment > hold)
- clear=1: bcd<=0, saturated<=0. Clear wins over a simultaneous tick or run.
- run=1 and tick and bcd!=16'h9999: ripple BCD increment.
  - Each digit 9→0 generates a carry; digits never take values A-F.
- run=1 and tick and bcd==16'h9999: bcd holds 9999, saturated<=1.
  - A full-scale display therefore reads 9999, not a wrap to 0000.
- run=0: bcd and saturated hold; the prescaler keeps running.
- Latency: bcd changes on the same edge the internal tick is sampled, i.e. DIV cycles after a clear edge, then every DIV cycles.
- saturated is sticky until clear or reset.
- No illegal states: the prescaler wraps by compare; nibbles are only loaded with 0-9 values.

Decomposition:
- Shared include rt_timer_consts.v holds:
  - TURBO_DIV default
  - normal divide constant (100_000)
  - BCD_MAX = 16'h9999
- The include is used by this block, the FSM and the testbench alongside timing.v.
- One natural sub-module: bcd_digit, a 4-bit decade counter.
  - Inputs: clk, reset, clear, inc.
  - Outputs: q[3:0], carry = inc & (q==9).
  - Instantiated 4x in a carry chain. The top level adds the prescaler and the saturation gate (increment suppressed when all digits are 9).

Test Plan:
1. Hold reset low, no clock edges → bcd=0000, saturated=0, tick_ms=0 immediately. Release; with run=0 and turbosim=1, tick_ms pulses every 100 cycles and bcd stays 0000.
2. turbosim=1: clear pulse, then run=1 for exactly 100_000 cycles after the clear edge → bcd=16'h1000 exactly. Drop run → value holds for 1000 further cycles.
3. Carry chain: count to 0x0099 → next tick gives 0x0100. From 0x0999 → 0x1000. Never observe any nibble >9 (monitor every cycle).
4. Saturation: run=1 for 10_001 ticks → bcd=0x9999, saturated=1. 50 more ticks → unchanged. clear → 0000, saturated=0.
5. Assert clear on the same edge as a tick with run=1 → bcd=0000, tick_ms=0. Next increment (to 0001) occurs exactly 100 cycles later.
6. turbosim=0, run=1: 100_000 cycles → bcd=0001. Switch turbosim 0→1 with pre≈50_000 → wrap on the next edge, then 100-cycle period. Async reset pulse mid-run → bcd=0000 without a clock edge.
